bip_control: RTL and testbench
==============================

BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 Parameter PC_W, default 11: program-counter and operand-address width.
REQ-002 Parameter INSTR_W, default 16: instruction width; opcode is [15:11], operand is [10:0].
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port Reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port Start, input, 1: program-start request; sampled only in IDLE.
REQ-006 Port Instr, input, INSTR_W: instruction-memory read data, valid one cycle after Instr_Addr is presented.
REQ-007 Port Instr_Addr, output, PC_W: instruction-memory address; equals PC.
REQ-008 Port SelA, output, 2: accumulator source; 00 = ALU, 01 = sign-extended operand, 10 = data memory.
REQ-009 Port SelB, output, 1: ALU B source; 0 = sign-extended operand, 1 = data memory.
REQ-010 Port WrAcc, output, 1: accumulator write enable.
REQ-011 Port Op, output, 1: ALU operation; 1 = add, 0 = subtract.
REQ-012 Port Clear, output, 1: accumulator clear pulse.
REQ-013 Port Addr, output, PC_W: operand field driven to sign extension and data memory.
REQ-014 Port RdRam, output, 1: data-memory read strobe.
REQ-015 Port WrRam, output, 1: data-memory write strobe.
REQ-016 Port Done, output, 1: program halted.
REQ-017 Port Cycles, output, 16: executed-clock count.

Function
REQ-018 FSM states: IDLE, FETCH, DECODE, EXEC, HALT; each instruction takes exactly 3 cycles (FETCH, DECODE, EXEC).
REQ-019 IDLE: Start=1 moves to FETCH, sets PC=0 and asserts Clear for that one cycle; otherwise the FSM stays in IDLE.
REQ-020 FETCH: drive Instr_Addr=PC, then go to DECODE.
REQ-021 DECODE: latch Instr into IR and drive Addr=IR operand from the next cycle through EXEC.
- RdRam=1 in the cycle after the latch when the opcode is LD, ADD or SUB.
REQ-022 EXEC behaviour per opcode:
- HLT 00000: go to HALT; PC holds.
- STO 00001: WrRam=1.
- LD 00010: SelA=10, WrAcc=1.
- LDI 00011: SelA=01, WrAcc=1.
- ADD 00100: SelA=00, SelB=1, Op=1, WrAcc=1.
- ADDI 00101: SelA=00, SelB=0, Op=1, WrAcc=1.
- SUB 00110: SelA=00, SelB=1, Op=0, WrAcc=1.
- SUBI 00111: SelA=00, SelB=0, Op=0, WrAcc=1.
REQ-023 Every opcode other than HLT increments PC at the end of EXEC and returns to FETCH.
REQ-024 Undefined opcodes 01000-11111 execute as NOP: no strobes, PC increments.
REQ-025 WrAcc, WrRam, RdRam and Clear are single-cycle pulses, never asserted outside the states named above.
REQ-026 SelA, SelB and Op are 0 whenever WrAcc=0.
REQ-027 PC wraps from 2^PC_W-1 to 0 without halting.
REQ-028 HALT: Done=1 and all strobes are 0; the FSM leaves HALT only via Reset_n or Start=1, which behaves exactly as Start in IDLE.
REQ-029 Start is ignored in FETCH, DECODE and EXEC.

Reset
REQ-030 Reset_n low asynchronously forces state=IDLE, PC=0, IR=0 and Cycles=0.
REQ-031 While Reset_n is low, every output is 0.
REQ-032 Reset mid-instruction aborts the instruction with no strobe emitted after assertion.
REQ-033 Release is synchronous-safe: the first transition out of IDLE occurs on the first rising edge with Reset_n high and Start=1.

Configuration
REQ-034 Macro BIP_CYCLE_COUNTER_EN defined: Cycles clears on Start acceptance, increments every cycle outside IDLE/HALT, saturates at 16'hFFFF, and holds in HALT.
REQ-035 Macro BIP_CYCLE_COUNTER_EN undefined: the Cycles port remains and is tied to 0, and no counter flops are synthesised.

Structure
REQ-036 Opcode encodings, FSM state encodings and SelA encodings reside in a shared include file (bip_defs) used by the datapath, top level and bench.
REQ-037 The PC register with load-zero, increment and hold controls is a sub-module named program_counter; decode stays inline.

Verification
REQ-038 Reset then Start; program LDI 5, ADDI 3, STO 10, HLT -> WrRam pulse with Addr=10 in cycle 9; Done=1 from cycle 13; Cycles=12 (with macro).
REQ-039 Program LD 4, SUB 4, HLT -> RdRam at DECODE+1 of both LD and SUB; second EXEC has SelA=00, SelB=1, Op=0, WrAcc=1.
REQ-040 Opcode 11111 at address 0, then HLT -> no strobes for that instruction; PC=1; halt at PC=1.
REQ-041 Reset_n pulsed low during EXEC of ADDI -> WrAcc falls immediately; state IDLE; outputs 0; Start restarts at PC=0 with a Clear pulse.
REQ-042 Start held high continuously through a 2-instruction program -> no restart until HALT; on HALT with Start still 1, the program reruns from PC=0.
REQ-043 PC_W=3 build with 8 NOPs then HLT at address 0 after wrap -> PC sequence 0..7,0, Done asserts.

Source files
------------

// File: rtl/bip_control_pkg.sv
// Shared encodings for the BIP control unit: FSM states, opcodes, accumulator source selects.
package bip_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_ALU = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_MEM = 2'b10;

    localparam logic [15:0] CYCLES_MAX = 16'hFFFF;

    // Opcodes whose operand is fetched from data memory.
    function automatic logic reads_mem(input logic [OPC_W-1:0] opc);
        return (opc == OP_LD) || (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

endpackage

// File: rtl/bip_control_program_counter.sv
// Program counter register: load-zero on program start, increment after EXEC, otherwise hold.
module program_counter #(
    parameter int PC_W = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_zero,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_r;

    // PC update; increment wraps naturally at 2^PC_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= '0;
        end else if (load_zero) begin
            pc_r <= '0;
        end else if (inc) begin
            pc_r <= pc_r + PC_W'(1);
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/bip_control.sv
// BIP control unit: 3-cycle FETCH/DECODE/EXEC sequencer with registered datapath strobes.
// Optional executed-cycle counter enabled by defining BIP_CYCLE_COUNTER_EN.
module bip_control
    import bip_control_pkg::*;
#(
    parameter int PC_W    = 11,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [INSTR_W-1:0] Instr,
    output logic [PC_W-1:0]    Instr_Addr,
    output logic [1:0]         SelA,
    output logic               SelB,
    output logic               WrAcc,
    output logic               Op,
    output logic               Clear,
    output logic [PC_W-1:0]    Addr,
    output logic               RdRam,
    output logic               WrRam,
    output logic               Done,
    output logic [15:0]        Cycles
);

    state_t               state_r;
    logic [INSTR_W-1:0]   ir_r;
    logic [1:0]           sel_a_r;
    logic                 sel_b_r;
    logic                 wr_acc_r;
    logic                 op_r;
    logic                 clear_r;
    logic                 rd_ram_r;
    logic                 wr_ram_r;
    logic                 done_r;

    logic [OPC_W-1:0]     instr_op_s;
    logic [OPC_W-1:0]     ir_op_s;
    logic                 start_accept_s;
    logic                 pc_load_zero_s;
    logic                 pc_inc_s;
    logic [PC_W-1:0]      pc_s;

    assign instr_op_s = Instr[INSTR_W-1 -: OPC_W];
    assign ir_op_s    = ir_r[INSTR_W-1 -: OPC_W];

    // Start is honoured only from IDLE or HALT; a halted program restarts exactly like a fresh one.
    always_comb begin
        start_accept_s = 1'b0;
        pc_load_zero_s = 1'b0;
        pc_inc_s       = 1'b0;
        if (((state_r == ST_IDLE) || (state_r == ST_HALT)) && Start) begin
            start_accept_s = 1'b1;
            pc_load_zero_s = 1'b1;
        end else if ((state_r == ST_EXEC) && (ir_op_s != OP_HLT)) begin
            pc_inc_s = 1'b1;
        end else begin
            pc_load_zero_s = 1'b0;
            pc_inc_s       = 1'b0;
        end
    end

    program_counter #(.PC_W(PC_W)) u_pc (
        .clk       (clk),
        .rst_n     (Reset_n),
        .load_zero (pc_load_zero_s),
        .inc       (pc_inc_s),
        .pc        (pc_s)
    );

    // Sequencer; EXEC strobes are decoded from Instr as it is latched so they register into EXEC.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r  <= ST_IDLE;
            ir_r     <= '0;
            sel_a_r  <= 2'b00;
            sel_b_r  <= 1'b0;
            wr_acc_r <= 1'b0;
            op_r     <= 1'b0;
            clear_r  <= 1'b0;
            rd_ram_r <= 1'b0;
            wr_ram_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            sel_a_r  <= SELA_ALU;
            sel_b_r  <= 1'b0;
            wr_acc_r <= 1'b0;
            op_r     <= 1'b0;
            clear_r  <= 1'b0;
            rd_ram_r <= 1'b0;
            wr_ram_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_HALT: begin
                    if (Start) begin
                        state_r <= ST_FETCH;
                        clear_r <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir_r     <= Instr;
                    state_r  <= ST_EXEC;
                    rd_ram_r <= reads_mem(instr_op_s);
                    case (instr_op_s)
                        OP_STO:  wr_ram_r <= 1'b1;
                        OP_LD:   begin sel_a_r <= SELA_MEM; wr_acc_r <= 1'b1; end
                        OP_LDI:  begin sel_a_r <= SELA_IMM; wr_acc_r <= 1'b1; end
                        OP_ADD:  begin sel_b_r <= 1'b1; op_r <= 1'b1; wr_acc_r <= 1'b1; end
                        OP_ADDI: begin op_r <= 1'b1; wr_acc_r <= 1'b1; end
                        OP_SUB:  begin sel_b_r <= 1'b1; wr_acc_r <= 1'b1; end
                        OP_SUBI: wr_acc_r <= 1'b1;
                        default: wr_acc_r <= 1'b0;
                    endcase
                end
                ST_EXEC: begin
                    if (ir_op_s == OP_HLT) begin
                        state_r <= ST_HALT;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BIP_CYCLE_COUNTER_EN
    logic [15:0] cycles_r;
    logic        busy_s;

    assign busy_s = (state_r == ST_FETCH) || (state_r == ST_DECODE) || (state_r == ST_EXEC);

    // Executed-cycle counter: cleared on program start, saturating, frozen while halted.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cycles_r <= 16'd0;
        end else if (start_accept_s) begin
            cycles_r <= 16'd0;
        end else if (busy_s && (cycles_r != CYCLES_MAX)) begin
            cycles_r <= cycles_r + 16'd1;
        end else begin
            cycles_r <= cycles_r;
        end
    end

    assign Cycles = cycles_r;
`else
    assign Cycles = 16'd0;
`endif

    assign Instr_Addr = pc_s;
    assign Addr       = ir_r[PC_W-1:0];
    assign SelA       = sel_a_r;
    assign SelB       = sel_b_r;
    assign WrAcc      = wr_acc_r;
    assign Op         = op_r;
    assign Clear      = clear_r;
    assign RdRam      = rd_ram_r;
    assign WrRam      = wr_ram_r;
    assign Done       = done_r;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: default build plus a PC_W=3 instance for PC wrap-around.
module tb_bip_control;
    import bip_control_pkg::*;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Start = 1'b0;
    logic        Start_s = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_s;
    logic [15:0] imem [0:2047];
    logic [15:0] smem [0:7];

    logic [10:0] Instr_Addr, Addr;
    logic [1:0]  SelA;
    logic        SelB, WrAcc, Op, Clear, RdRam, WrRam, Done;
    logic [15:0] Cycles;

    logic [2:0]  Instr_Addr_s, Addr_s;
    logic [1:0]  SelA_s;
    logic        SelB_s, WrAcc_s, Op_s, Clear_s, RdRam_s, WrRam_s, Done_s;
    logic [15:0] Cycles_s;

    logic [7:0]  ctl, ctl_s;
    logic [46:0] all_out;

    int n_checks = 0;
    int n_fail = 0;

    assign ctl     = {Clear, WrAcc, WrRam, RdRam, SelA, SelB, Op};
    assign ctl_s   = {Clear_s, WrAcc_s, WrRam_s, RdRam_s, SelA_s, SelB_s, Op_s};
    assign all_out = {Instr_Addr, SelA, SelB, WrAcc, Op, Clear, Addr, RdRam, WrRam, Done, Cycles};

    always #5 clk = ~clk;

    always @(posedge clk) instr <= imem[Instr_Addr];
    always @(posedge clk) instr_s <= smem[Instr_Addr_s];

    bip_control dut (
        .clk(clk), .Reset_n(Reset_n), .Start(Start), .Instr(instr),
        .Instr_Addr(Instr_Addr), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc), .Op(Op),
        .Clear(Clear), .Addr(Addr), .RdRam(RdRam), .WrRam(WrRam), .Done(Done), .Cycles(Cycles)
    );

    bip_control #(.PC_W(3)) dut_small (
        .clk(clk), .Reset_n(Reset_n), .Start(Start_s), .Instr(instr_s),
        .Instr_Addr(Instr_Addr_s), .SelA(SelA_s), .SelB(SelB_s), .WrAcc(WrAcc_s), .Op(Op_s),
        .Clear(Clear_s), .Addr(Addr_s), .RdRam(RdRam_s), .WrRam(WrRam_s), .Done(Done_s),
        .Cycles(Cycles_s)
    );

    function automatic logic [15:0] enc(input logic [4:0] opc, input logic [10:0] opd);
        return {opc, opd};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) imem[i] = 16'h0000;
    endtask

    // Leaves the bench at a falling edge with Reset_n just released and the DUTs idle.
    task automatic do_reset();
        @(negedge clk);
        Reset_n = 1'b0;
        Start   = 1'b0;
        Start_s = 1'b0;
        @(negedge clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        Reset_n = 1'b0;
        Start   = 1'b1;
        #1;
        n_checks++;
        if (all_out !== 47'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        @(negedge clk);
        Start   = 1'b0;
        Reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ctl, Done, Instr_Addr} !== 20'd0) begin
            n_fail++; $display("FAIL idle_hold: got %h expected 0", {ctl, Done, Instr_Addr});
        end
    endtask

    // LDI 5, ADDI 3, STO 10, HLT
    task automatic test_store_program();
        logic [7:0]  exp_ctl [0:13];
        logic [15:0] exp_cycles;
        exp_ctl = '{8'h80, 8'h00, 8'h44, 8'h00, 8'h00, 8'h41, 8'h00,
                    8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef BIP_CYCLE_COUNTER_EN
        exp_cycles = 16'd12;
`else
        exp_cycles = 16'd0;
`endif
        clear_mem();
        imem[0] = enc(OP_LDI, 11'd5);
        imem[1] = enc(OP_ADDI, 11'd3);
        imem[2] = enc(OP_STO, 11'd10);
        imem[3] = enc(OP_HLT, 11'd0);
        do_reset();
        Start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            Start = 1'b0;
            n_checks++;
            if (ctl !== exp_ctl[c-1]) begin n_fail++; $display("FAIL store_ctl c%0d: got %h expected %h", c, ctl, exp_ctl[c-1]); end
            n_checks++;
            if (Done !== (c >= 13)) begin n_fail++; $display("FAIL store_done c%0d: got %b expected %b", c, Done, (c >= 13)); end
            if (c == 3) begin
                n_checks++;
                if (Addr !== 11'd5) begin n_fail++; $display("FAIL ldi_addr: got %0d expected 5", Addr); end
            end
            if (c == 9) begin
                n_checks++;
                if (Addr !== 11'd10) begin n_fail++; $display("FAIL sto_addr: got %0d expected 10", Addr); end
            end
            if (c == 7) begin
                n_checks++;
                if (Instr_Addr !== 11'd2) begin n_fail++; $display("FAIL store_pc: got %0d expected 2", Instr_Addr); end
            end
            if (c >= 13) begin
                n_checks++;
                if (Cycles !== exp_cycles) begin n_fail++; $display("FAIL store_cycles c%0d: got %0d expected %0d", c, Cycles, exp_cycles); end
            end
        end
    endtask

    // LD 4, SUB 4, HLT
    task automatic test_load_sub();
        logic [7:0] exp_ctl [0:9];
        exp_ctl = '{8'h80, 8'h00, 8'h58, 8'h00, 8'h00, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_mem();
        imem[0] = enc(OP_LD, 11'd4);
        imem[1] = enc(OP_SUB, 11'd4);
        do_reset();
        Start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            Start = 1'b0;
            n_checks++;
            if (ctl !== exp_ctl[c-1]) begin n_fail++; $display("FAIL ldsub_ctl c%0d: got %h expected %h", c, ctl, exp_ctl[c-1]); end
            if (c == 6) begin
                n_checks++;
                if (Addr !== 11'd4) begin n_fail++; $display("FAIL sub_addr: got %0d expected 4", Addr); end
            end
        end
        n_checks++;
        if (Done !== 1'b1) begin n_fail++; $display("FAIL ldsub_done: got %b expected 1", Done); end
    endtask

    // Undefined opcode 11111 then HLT
    task automatic test_nop();
        clear_mem();
        imem[0] = 16'hF800;
        do_reset();
        Start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            Start = 1'b0;
            n_checks++;
            if (ctl !== ((c == 1) ? 8'h80 : 8'h00)) begin n_fail++; $display("FAIL nop_ctl c%0d: got %h", c, ctl); end
            if (c == 4 || c == 7) begin
                n_checks++;
                if (Instr_Addr !== 11'd1) begin n_fail++; $display("FAIL nop_pc c%0d: got %0d expected 1", c, Instr_Addr); end
            end
        end
        n_checks++;
        if (Done !== 1'b1) begin n_fail++; $display("FAIL nop_done: got %b expected 1", Done); end
    endtask

    task automatic test_reset_mid();
        clear_mem();
        imem[0] = enc(OP_ADDI, 11'd7);
        do_reset();
        Start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            Start = 1'b0;
        end
        n_checks++;
        if (ctl !== 8'h41) begin n_fail++; $display("FAIL mid_exec_ctl: got %h expected 41", ctl); end
        #2;
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if (all_out !== 47'd0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0", all_out); end
        @(negedge clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ctl, Done, Instr_Addr} !== 20'd0) begin n_fail++; $display("FAIL mid_idle: got %h expected 0", {ctl, Done, Instr_Addr}); end
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        n_checks++;
        if ({ctl, Instr_Addr} !== {8'h80, 11'd0}) begin n_fail++; $display("FAIL mid_restart: got %h expected %h", {ctl, Instr_Addr}, {8'h80, 11'd0}); end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ctl, Addr} !== {8'h41, 11'd7}) begin n_fail++; $display("FAIL mid_rerun: got %h expected %h", {ctl, Addr}, {8'h41, 11'd7}); end
    endtask

    // ADDI 1, HLT with Start held high throughout
    task automatic test_start_held();
        logic [7:0] exp_ctl [0:7];
        exp_ctl = '{8'h80, 8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        clear_mem();
        imem[0] = enc(OP_ADDI, 11'd1);
        do_reset();
        Start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (ctl !== exp_ctl[c-1]) begin n_fail++; $display("FAIL held_ctl c%0d: got %h expected %h", c, ctl, exp_ctl[c-1]); end
            n_checks++;
            if (Done !== (c == 7)) begin n_fail++; $display("FAIL held_done c%0d: got %b expected %b", c, Done, (c == 7)); end
            if (c == 4 || c == 8) begin
                n_checks++;
                if (Instr_Addr !== ((c == 4) ? 11'd1 : 11'd0)) begin n_fail++; $display("FAIL held_pc c%0d: got %0d", c, Instr_Addr); end
            end
        end
        Start = 1'b0;
    endtask

    // PC_W=3: eight NOPs, PC wraps to 0 where a HLT now sits
    task automatic test_wrap();
        int k;
        for (int i = 0; i < 8; i++) smem[i] = 16'hF800;
        do_reset();
        Start_s = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            Start_s = 1'b0;
            n_checks++;
            if (ctl_s !== ((c == 1) ? 8'h80 : 8'h00)) begin n_fail++; $display("FAIL wrap_ctl c%0d: got %h", c, ctl_s); end
            if ((c % 3 == 1) && (c <= 25)) begin
                k = (c - 1) / 3;
                n_checks++;
                if (Instr_Addr_s !== 3'(k)) begin n_fail++; $display("FAIL wrap_pc c%0d: got %0d expected %0d", c, Instr_Addr_s, 3'(k)); end
                if (k == 7) smem[0] = enc(OP_HLT, 11'd0);
            end
            if (c >= 27) begin
                n_checks++;
                if (Done_s !== (c == 28)) begin n_fail++; $display("FAIL wrap_done c%0d: got %b expected %b", c, Done_s, (c == 28)); end
            end
        end
        n_checks++;
        if (Instr_Addr_s !== 3'd0) begin n_fail++; $display("FAIL wrap_halt_pc: got %0d expected 0", Instr_Addr_s); end
    endtask

    initial begin
        clear_mem();
        for (int i = 0; i < 8; i++) smem[i] = 16'h0000;
        test_reset();
        test_store_program();
        test_load_sub();
        test_nop();
        test_reset_mid();
        test_start_held();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
